// File: rtl/regfile_status.sv
// Register file (two combinational read ports, one write port) plus Z/N status flags.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data and flags to the outputs.
module regfile_status #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              zin,
  input  logic              nin,
  output logic              zflag,
  output logic              nflag
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              z_q;
  logic              n_q;
  logic              wr_ok;
  logic              rs_is_zero;
  logic              rt_is_zero;

  // Writes aimed at a hardwired-zero register 0 never touch storage.
  assign wr_ok      = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign rs_is_zero = (ZERO_REG != 0) && (rs_addr == '0);
  assign rt_is_zero = (ZERO_REG != 0) && (rt_addr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (flag_we) begin
      z_q <= zin;
      n_q <= nin;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic fwd_ok;

  // Forwarding is suppressed under reset so reads stay zero while reset is held.
  assign fwd_ok = wr_ok && !reset;

  always_comb begin
    rs_data = rs_is_zero ? '0 : mem[rs_addr];
    rt_data = rt_is_zero ? '0 : mem[rt_addr];
    if (fwd_ok && (wr_addr == rs_addr)) begin
      rs_data = wr_data;
    end
    if (fwd_ok && (wr_addr == rt_addr)) begin
      rt_data = wr_data;
    end
  end

  assign zflag = (flag_we && !reset) ? zin : z_q;
  assign nflag = (flag_we && !reset) ? nin : n_q;
`else
  always_comb begin
    rs_data = rs_is_zero ? '0 : mem[rs_addr];
    rt_data = rt_is_zero ? '0 : mem[rt_addr];
  end

  assign zflag = z_q;
  assign nflag = n_q;
`endif

endmodule

// File: tb/tb_regfile_status.sv
// Directed bench for regfile_status: reset, read/write, register zero, same-cycle write, flags.
module tb_regfile_status;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        wr_en, flag_we, zin, nin;
  logic        zflag, nflag;
  logic [31:0] rs_data0, rt_data0;
  logic        zflag0, nflag0;

  int checks = 0;
  int errors = 0;

  regfile_status #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flag_we(flag_we), .zin(zin), .nin(nin),
    .zflag(zflag), .nflag(nflag)
  );

  // Same stimulus, register 0 behaves as an ordinary register.
  regfile_status #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data0), .rt_data(rt_data0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flag_we(flag_we), .zin(zin), .nin(nin),
    .zflag(zflag0), .nflag(nflag0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rs_addr = 5'd5; rt_addr = 5'd0; wr_addr = 5'd0; wr_data = '0;
    wr_en = 1'b0; flag_we = 1'b0; zin = 1'b0; nin = 1'b0;
    #1;
    check("reset_rs", rs_data, 32'h0);
    check("reset_z", {31'b0, zflag}, 32'h0);
    check("reset_n", {31'b0, nflag}, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Load reg5 and flags, then assert reset mid-cycle.
    write_reg(5'd5, 32'hDEADBEEF);
    rs_addr = 5'd5; #1;
    check("load_reg5", rs_data, 32'hDEADBEEF);
    flag_we = 1'b1; zin = 1'b1; nin = 1'b1;
    tick();
    flag_we = 1'b0; #1;
    check("load_z", {31'b0, zflag}, 32'h1);
    check("load_n", {31'b0, nflag}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_rs", rs_data, 32'h0);
    check("async_rst_z", {31'b0, zflag}, 32'h0);
    check("async_rst_n", {31'b0, nflag}, 32'h0);
    #1 reset = 1'b0;
    tick();

    write_reg(5'd7, 32'h12345678);
    write_reg(5'd31, 32'hFFFFFFFF);
    rs_addr = 5'd7; rt_addr = 5'd31; #1;
    check("rd_reg7", rs_data, 32'h12345678);
    check("rd_reg31", rt_data, 32'hFFFFFFFF);
    rt_addr = 5'd7; #1;
    check("same_addr_rt", rt_data, 32'h12345678);
    check("same_addr_rs", rs_data, 32'h12345678);

    wr_en = 1'b0; wr_addr = 5'd7; wr_data = 32'h0BAD0BAD;
    tick();
    check("no_wr_en_hold", rs_data, 32'h12345678);

    write_reg(5'd0, 32'hA5A5A5A5);
    rs_addr = 5'd0; #1;
    check("reg0_hardwired", rs_data, 32'h0);
    check("reg0_ordinary", rs_data0, 32'hA5A5A5A5);

    // Same-cycle read/write of reg3, old 1 new 2.
    write_reg(5'd3, 32'd1);
    rs_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd2; #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rdw_before_edge", rs_data, 32'd2);
`else
    check("rdw_before_edge", rs_data, 32'd1);
`endif
    tick();
    wr_en = 1'b0; #1;
    check("rdw_after_edge", rs_data, 32'd2);

    // A write to register 0 must not be forwarded to a read of register 0.
    rs_addr = 5'd0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h77777777; #1;
    check("reg0_no_fwd", rs_data, 32'h0);
    tick();
    wr_en = 1'b0; #1;
    check("reg0_after_wr", rs_data, 32'h0);

    // Flags.
    flag_we = 1'b1; zin = 1'b1; nin = 1'b0; #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("flag_pre_z", {31'b0, zflag}, 32'h1);
`else
    check("flag_pre_z", {31'b0, zflag}, 32'h0);
`endif
    tick();
    flag_we = 1'b0; zin = 1'b0; nin = 1'b1; #1;
    check("flag_set_z", {31'b0, zflag}, 32'h1);
    check("flag_set_n", {31'b0, nflag}, 32'h0);
    tick();
    check("flag_hold_z", {31'b0, zflag}, 32'h1);
    check("flag_hold_n", {31'b0, nflag}, 32'h0);
    flag_we = 1'b1;
    tick();
    flag_we = 1'b0; #1;
    check("flag_upd_z", {31'b0, zflag}, 32'h0);
    check("flag_upd_n", {31'b0, nflag}, 32'h1);

    // Reset colliding with a write at a clock edge.
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; rs_addr = 5'd9; #1;
    check("rst_wr_during", rs_data, 32'h0);
    tick();
    check("rst_wr_edge", rs_data, 32'h0);
    reset = 1'b0; wr_en = 1'b0; #1;
    check("rst_wr_lost", rs_data, 32'h0);
    check("rst_clr_reg7", rt_data, 32'h0);
    write_reg(5'd9, 32'h55);
    #1;
    check("first_wr_after_rst", rs_data, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_status.md
Name: regfile_status

Overview:
- Register file and status-flag register feeding the 32-bit ALU in the MIPS-style datapath.
- Two combinational read ports supply ALU operands a and b.
- One synchronous write port takes the writeback result.
- A 2-bit status register (Z, N) captures the ALU zout/nout flags for status-based branch/jump instructions in the next instruction.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W (32 registers).
- ZERO_REG, 1, when 1 register 0 is hardwired to zero; when 0 it is an ordinary register.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous active-high reset.
- rs_addr  input  ADDR_W  read port 1 address (ALU operand a).
- rt_addr  input  ADDR_W  read port 2 address (ALU operand b).
- rs_data  output  DATA_W  read port 1 data.
- rt_data  output  DATA_W  read port 2 data.
- wr_en  input  1  register write enable (RegWrite).
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data (writeback value).
- flag_we  input  1  status register update enable.
- zin  input  1  zero flag from ALU (zout).
- nin  input  1  negative flag from ALU (nout).
- zflag  output  1  latched Z status.
- nflag  output  1  latched N status.

Behaviour:
- Reset:
  - Asynchronous, active-high; takes effect immediately, independent of clk.
  - Clears all registers to 0 and zflag/nflag to 0.
  - While reset is high, rs_data/rt_data read 0 for every address.
  - Reset asserted in the same cycle as a write: reset wins, the write is lost.
  - After reset deasserts, the first write lands on the next rising clk edge.
- Reads:
  - Purely combinational, zero latency: rs_data = reg[rs_addr], rt_data = reg[rt_addr].
  - Both ports are independent; the same address on both ports returns identical data.
- Register 0 (ZERO_REG=1):
  - Always reads 0.
  - A write with wr_addr=0 is ignored; no storage is updated.
- Writes:
  - On rising clk with wr_en=1 and reset=0: reg[wr_addr] <= wr_data.
  - With wr_en=0: no register changes, wr_addr/wr_data are don't-care.
- Read-during-write, same address, same cycle: see Optional Feature. Default is the old value until the edge, new value after.
- Status register:
  - On rising clk with flag_we=1: zflag <= zin, nflag <= nin.
  - With flag_we=0: flags hold.
  - Flag update and register write are independent and may occur in the same cycle.
- Latency: write-to-read is 1 cycle (value visible combinationally right after the edge); flag-to-output is 1 cycle.
- Widths: no sign extension or truncation; data is stored and returned bit-exact.
- Out-of-range addresses are impossible (depth = 2**ADDR_W).
- X on wr_addr while wr_en=1 is illegal stimulus; the bench must not drive it.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - When wr_en=1, wr_addr=rs_addr (or rt_addr) and wr_addr is not 0 (ZERO_REG=1), the matching read port returns wr_data combinationally in the same cycle.
  - This is internal write-through forwarding for same-cycle writeback/decode.
  - Same forwarding applies to flags: when flag_we=1, zflag/nflag show zin/nin combinationally.
- Undefined:
  - Reads return stored contents only.
  - Flags show latched values only.
  - New data appears after the rising edge.

Test Plan:
- Reset check: assert reset mid-cycle after loading reg5=32'hDEADBEEF -> rs_data for addr 5 = 0 immediately, without a clk edge; zflag=nflag=0.
- Write/read: write reg7=32'h12345678, reg31=32'hFFFFFFFF -> next cycle rs_addr=7, rt_addr=31 give 32'h12345678 and 32'hFFFFFFFF.
- Register zero: write reg0=32'hA5A5A5A5 -> rs_addr=0 reads 0. Repeat with ZERO_REG=0 -> reads 32'hA5A5A5A5.
- Same-cycle read/write of reg3 (old 1, new 2):
  - Without macro: 1 before the edge, 2 after.
  - With REGFILE_WRITE_BYPASS_EN: 2 in the same cycle.
- Flags:
  - zin=1, nin=0, flag_we=1 -> zflag=1, nflag=0 after the edge.
  - Then zin=0, nin=1, flag_we=0 -> flags hold 1/0.
  - Then flag_we=1 -> flags become 0/1.
- Reset vs write collision: reset=1 with wr_en=1, wr_addr=9, wr_data=32'h55 at a clk edge -> reg9 = 0 after reset release.
